// File: rtl/dmem_pkg.sv
// Shared types, constants and address-check helper for the data-memory responder.
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 32'd4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;
    localparam int unsigned CNT_W      = 32'd4;

    // True when addr falls inside [base, base + depth*WORD_BYTES). The upper
    // bound is computed in 33 bits so a window ending at 4 GiB cannot wrap.
    function automatic bit in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
        logic [32:0] limit_s;
        limit_s = {1'b0, base} + ({1'b0, depth} * 33'(WORD_BYTES));
        return (addr >= base) && ({1'b0, addr} < limit_s);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 storage with a synchronous write port and a registered read
// port sharing one word index. Contents are never reset; only the read
// register is, and it holds zero whenever no read is being returned.
module dmem_ram #(
    parameter int unsigned DEPTH = 32'd64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Array write on the edge the request commits
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Read register: loads the addressed word for a read, zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= mem_r[idx];
        end else begin
            rdata_r <= 32'h0000_0000;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: accepts one word request at a
// time, waits WAIT_CYCLES, then returns a one-cycle ack with read data or an
// error flag for misaligned / out-of-window addresses.
module dmem_responder #(
    parameter int unsigned DEPTH       = 32'd64,
    parameter int unsigned WAIT_CYCLES = 32'd2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        stall
);
    import dmem_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(WAIT_CYCLES - 32'd1);

    state_t             state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic               we_r;
    logic [31:0]        addr_r, wdata_r;
    logic               ack_r, err_r;

    logic               cur_we_s;
    logic [31:0]        cur_addr_s, cur_wdata_s, offset_s;
    logic [AW-1:0]      idx_s;
    logic               bad_s, enter_resp_s, ram_we_s, ram_re_s;
    logic [31:0]        ram_rdata_s;

    // Request being served: live inputs while idle (so a zero-wait request
    // can commit on its accept edge), the latched copy once accepted
    always_comb begin
        cur_we_s    = we_r;
        cur_addr_s  = addr_r;
        cur_wdata_s = wdata_r;
        if (state_r == IDLE) begin
            cur_we_s    = we;
            cur_addr_s  = addr;
            cur_wdata_s = wdata;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
    end

    // Address decode: word index within the window and the error condition
    always_comb begin
        offset_s = cur_addr_s - BASE_ADDR;
        idx_s    = AW'(offset_s >> 5'd2);
        bad_s    = ((cur_addr_s[1:0] & ALIGN_MASK) != 2'b00) ||
                   !in_range(cur_addr_s, BASE_ADDR, DEPTH);
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 32'd0) begin
                        state_nx_s = RESP;
                    end else begin
                        state_nx_s = WAIT;
                        cnt_nx_s   = CNT_INIT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx_s = RESP;
                end else begin
                    cnt_nx_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // The edge entering RESP is the commit point for writes and reads
    always_comb begin
        enter_resp_s = (state_nx_s == RESP);
        ram_we_s     = enter_resp_s && cur_we_s && !bad_s;
        ram_re_s     = enter_resp_s && !cur_we_s && !bad_s;
    end

    // State, counter and request latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if ((state_r == IDLE) && req) begin
                we_r    <= we;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
        end
    end

    // Response strobes: high only during the RESP cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ack_r <= enter_resp_s;
            err_r <= enter_resp_s && bad_s;
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .idx   (idx_s),
        .wdata (cur_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign ack   = ack_r;
    assign err   = err_r;
    assign rdata = ram_rdata_s;
    // Hold the pipeline while a request is presented in IDLE or waiting
    assign stall = ((state_r == IDLE) && req) || (state_r == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (2 wait states at base
// 0 with 64 words, 0 wait states at base 0x1000 with 16 words), a directed
// vector table, hand sequences for back-to-back and reset abort, and random
// traffic checked against an array-based reference model.
module tb_dmem_responder;

    localparam logic [31:0] BASE_A  = 32'h0000_0000;
    localparam logic [31:0] BASE_B  = 32'h0000_1000;
    localparam int          DEPTH_A = 64;
    localparam int          DEPTH_B = 16;
    localparam int          WAIT_A  = 2;
    localparam int          WAIT_B  = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, we_a, ack_a, err_a, stall_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ack_b, err_b, stall_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem_a [DEPTH_A];
    logic [31:0] mem_b [DEPTH_B];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A), .BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ack(ack_a), .err(err_a), .stall(stall_a));

    dmem_responder #(.DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ack(ack_b), .err(err_b), .stall(stall_b));

    typedef struct {
        int          sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chg;
        logic [31:0] alt_addr;
        logic [31:0] alt_wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [31:0] base_of(input int sel);
        return (sel == 0) ? BASE_A : BASE_B;
    endfunction
    function automatic int depth_of(input int sel);
        return (sel == 0) ? DEPTH_A : DEPTH_B;
    endfunction
    function automatic int wait_of(input int sel);
        return (sel == 0) ? WAIT_A : WAIT_B;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: an access is an error if not word aligned or outside the window
    function automatic bit model_err(input int sel, input logic [31:0] a);
        longint unsigned lo, hi, x;
        lo = base_of(sel);
        hi = lo + 4 * depth_of(sel);
        x  = a;
        return (a % 32'd4 != 32'd0) || (x < lo) || (x >= hi);
    endfunction

    task automatic model_access(input int sel, input logic w, input logic [31:0] a,
                                input logic [31:0] d, output logic e, output logic [31:0] rd);
        int idx;
        e  = model_err(sel, a);
        rd = 32'h0;
        if (!e) begin
            idx = int'((a - base_of(sel)) / 32'd4);
            if (w) begin
                if (sel == 0) mem_a[idx] = d; else mem_b[idx] = d;
            end else begin
                rd = (sel == 0) ? mem_a[idx] : mem_b[idx];
            end
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            req_a = r; we_a = w; addr_a = a; wdata_a = d;
        end else begin
            req_b = r; we_b = w; addr_b = a; wdata_b = d;
        end
    endtask

    task automatic sample(input int sel, output logic k, output logic s,
                          output logic e, output logic [31:0] rd);
        if (sel == 0) begin
            k = ack_a; s = stall_a; e = err_a; rd = rdata_a;
        end else begin
            k = ack_b; s = stall_b; e = err_b; rd = rdata_b;
        end
    endtask

    // One request with protocol timing checks; returns the err/rdata seen with ack
    task automatic run_txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input bit chg, input logic [31:0] alt_a, input logic [31:0] alt_d,
                           output logic e_o, output logic [31:0] rd_o);
        int lat, stalls;
        logic k, s, e;
        logic [31:0] rd;
        lat = -1; stalls = 0; e_o = 1'bx; rd_o = 32'hxxxx_xxxx;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        for (int c = 0; c < 40; c++) begin
            #1;
            sample(sel, k, s, e, rd);
            if (k) begin
                lat = c; e_o = e; rd_o = rd;
                check("stall_in_resp", s, 32'd0);
                drive(sel, 1'b0, w, a, d);
                break;
            end
            if (s) stalls++;
            if (chg && c == 1) drive(sel, 1'b1, w, alt_a, alt_d);
            @(negedge clk);
        end
        drive(sel, 1'b0, w, a, d);
        check("ack_latency", lat, wait_of(sel) + 1);
        check("stall_cycles", stalls, wait_of(sel) + 1);
        @(negedge clk);
        #1;
        sample(sel, k, s, e, rd);
        check("ack_one_cycle", k, 32'd0);
        check("err_after_resp", e, 32'd0);
        check("rdata_after_resp", rd, 32'd0);
        check("stall_after_resp", s, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e_m, e_g, k, s, e;
        logic [31:0] d_m, d_g, rd, a;
        int          sel, r, first, second;
        bit          chg, w;

        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sample(i, k, s, e, rd);
            check("reset_ack", k, 32'd0);
            check("reset_err", e, 32'd0);
            check("reset_rdata", rd, 32'd0);
            check("reset_stall", s, 32'd0);
        end
        reset = 1'b1;

        // Fill both arrays with a known pattern so every later read is defined
        for (int i = 0; i < DEPTH_A; i++) begin
            model_access(0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), e_m, d_m);
            run_txn(0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 1'b0, 32'h0, 32'h0, e_g, d_g);
            check("fill_a_err", e_g, 32'd0);
        end
        for (int i = 0; i < DEPTH_B; i++) begin
            model_access(1, 1'b1, BASE_B + 32'(i * 4), 32'hB600_0000 | 32'(i), e_m, d_m);
            run_txn(1, 1'b1, BASE_B + 32'(i * 4), 32'hB600_0000 | 32'(i), 1'b0, 32'h0, 32'h0, e_g, d_g);
            check("fill_b_err", e_g, 32'd0);
        end

        // Directed vectors: sel, we, addr, wdata, chg, alt_addr, alt_wdata, exp_err, exp_rdata
        vecs.push_back('{0, 1'b1, 32'h10,   32'hDEAD_BEEF, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h10,   32'h0,         1'b0, 32'h0,  32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1, 1'b1, 32'h1000, 32'h1234_5678, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h1000, 32'h0,         1'b0, 32'h0,  32'h0,         1'b0, 32'h1234_5678});
        vecs.push_back('{0, 1'b1, 32'h13,   32'hFFFF_FFFF, 1'b0, 32'h0,  32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h10,   32'h0,         1'b0, 32'h0,  32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b0, 32'hFC,   32'h0,         1'b0, 32'h0,  32'h0,         1'b0, 32'hA500_003F});
        vecs.push_back('{0, 1'b0, 32'h100,  32'h0,         1'b0, 32'h0,  32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 1'b1, 32'h10,   32'h1111_2222, 1'b1, 32'h20, 32'h3333_4444, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h10,   32'h0,         1'b0, 32'h0,  32'h0,         1'b0, 32'h1111_2222});
        vecs.push_back('{0, 1'b0, 32'h20,   32'h0,         1'b0, 32'h0,  32'h0,         1'b0, 32'hA500_0008});
        vecs.push_back('{0, 1'b0, 32'h11,   32'h0,         1'b0, 32'h0,  32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0FFC, 32'h0,         1'b0, 32'h0,  32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h1040, 32'h0,         1'b0, 32'h0,  32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h103C, 32'h0,         1'b0, 32'h0,  32'h0,         1'b0, 32'hB600_000F});
        vecs.push_back('{1, 1'b1, 32'h1002, 32'h5555_AAAA, 1'b0, 32'h0,  32'h0,         1'b1, 32'h0});

        foreach (vecs[i]) begin
            model_access(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, e_m, d_m);
            run_txn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].chg, vecs[i].alt_addr, vecs[i].alt_wdata, e_g, d_g);
            check($sformatf("vec%0d_err", i), e_g, vecs[i].exp_err);
            check($sformatf("vec%0d_rdata", i), d_g, vecs[i].exp_rdata);
        end

        // Back-to-back: req held through RESP is only taken in the next IDLE
        model_access(0, 1'b0, 32'h10, 32'h0, e_m, d_m);
        first = -1; second = -1;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 0; c < 20; c++) begin
            #1;
            sample(0, k, s, e, rd);
            if (k) begin
                if (first < 0) begin
                    first = c;
                end else begin
                    second = c;
                    check("b2b_rdata", rd, d_m);
                    drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
                    break;
                end
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
        check("b2b_first_ack", first, WAIT_A + 1);
        check("b2b_second_ack", second, 2 * WAIT_A + 3);

        // Reset asserted mid-WAIT of a write to 0x08: aborted, nothing written
        model_access(0, 1'b0, 32'h08, 32'h0, e_m, d_m);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h08, 32'hCAFE_F00D);
        @(negedge clk);
        #1;
        sample(0, k, s, e, rd);
        check("abort_stall_wait", s, 32'd1);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            sample(0, k, s, e, rd);
            check("abort_ack", k, 32'd0);
            check("abort_stall", s, 32'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        run_txn(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 32'h0, e_g, d_g);
        check("abort_err", e_g, 32'd0);
        check("abort_rdata", d_g, d_m);

        // Random traffic against the reference model
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            if (r <= 5)      a = base_of(sel) + 32'(4 * $urandom_range(0, depth_of(sel) - 1));
            else if (r == 6) a = base_of(sel) + 32'($urandom_range(0, depth_of(sel) * 4 - 1));
            else if (r == 7) a = base_of(sel) + 32'(depth_of(sel) * 4) + 32'(4 * $urandom_range(0, 3));
            else if (r == 8) a = base_of(sel) - 32'(4 * $urandom_range(1, 4));
            else             a = $urandom();
            d_g = $urandom();
            chg = (sel == 0) && ($urandom_range(0, 3) == 0);
            model_access(sel, w, a, d_g, e_m, d_m);
            run_txn(sel, w, a, d_g, chg, $urandom(), $urandom(), e_g, d_g);
            check($sformatf("rnd%0d_err", n), e_g, e_m);
            check($sformatf("rnd%0d_rdata", n), d_g, d_m);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's data-memory port.
- Accepts word read and write requests, inserts a programmable number of wait states, and returns read data with a one-cycle acknowledge.
- Drives a stall back to the CPU while a request is outstanding.
- Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
- DEPTH, 64, number of 32-bit words in the array; must be a power of two, ≥ 2.
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  CPU request valid; held stable by the CPU while stall=1.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  32  byte address (CPU ALUResult).
- wdata  in  32  write data (CPU WriteDataM).
- rdata  out  32  read data; valid only when ack=1 and we_q=0.
- ack  out  1  one-cycle response strobe.
- err  out  1  error flag; valid only with ack.
- stall  out  1  combinational hold request to the CPU pipeline.

Behaviour:
- States: IDLE, WAIT, RESP. Reset forces IDLE asynchronously.
- Reset values: rdata=0, ack=0, err=0, wait counter=0, latched request cleared. stall=0 after reset, because it is combinational and req is qualified by IDLE.
- Array contents are not reset.
- Acceptance: in IDLE with req=1 on a clk edge, latch we, addr, wdata into we_q/addr_q/wdata_q.
  - Next state is WAIT with cnt=WAIT_CYCLES-1.
  - If WAIT_CYCLES=0, next state is RESP.
- WAIT: cnt decrements each cycle; at cnt=0 the next state is RESP. Input changes during WAIT are ignored because the latched copy is used.
- RESP: lasts one cycle, then IDLE unconditionally. A req present during RESP is not accepted; it is accepted in the following IDLE cycle.
- ack, err and rdata are registered and asserted during the RESP cycle only. Outside RESP: ack=0, err=0, rdata=0.
- Write: committed on the clock edge that enters RESP. Readable by any later request.
- Read: rdata returns the array word at (addr_q-BASE_ADDR)>>2 during RESP.
- Error: err=1 in RESP when either condition holds:
  - misaligned: addr_q[1:0]≠0;
  - out of range: addr_q<BASE_ADDR or addr_q≥BASE_ADDR+DEPTH*4.
  - On error: no array write and rdata=0.
- stall = (state==IDLE & req) | (state==WAIT); stall=0 in RESP.
- Request-to-ack latency is WAIT_CYCLES+1 cycles after the accept edge. Throughput is one request per WAIT_CYCLES+2 cycles.
- Boundaries:
  - The last word (BASE_ADDR+DEPTH*4-4) is legal; BASE_ADDR+DEPTH*4 is an error.
  - Address arithmetic is unsigned 32-bit with no wrap: addresses below BASE_ADDR are errors, not aliases.
- Reset mid-operation (WAIT or RESP): abort to IDLE. No write is committed unless the RESP entry edge already occurred. ack is not asserted for the aborted request.

Decomposition:
- Package dmem_pkg:
  - state_t enum (IDLE, WAIT, RESP);
  - WORD_BYTES=4 and ALIGN_MASK=2'b11;
  - function in_range(addr, base, depth) returning bit.
- Sub-module dmem_ram:
  - DEPTH×32 array;
  - synchronous write enable;
  - registered read port addressed by word index;
  - no reset on contents.
- The responder FSM and counter stay in dmem_responder.

Test Plan:
- Reset then WAIT_CYCLES=2: write req we=1 addr=0x10 wdata=0xDEADBEEF → stall=1 for 3 cycles, ack=1 err=0 on the 3rd edge after accept. A subsequent read of 0x10 → rdata=0xDEADBEEF with ack.
- WAIT_CYCLES=0: read of 0x0 after writing 0x12345678 → ack in the cycle after accept, stall high for exactly 1 cycle.
- Misaligned write addr=0x13 wdata=0xFFFFFFFF → ack=1 err=1 rdata=0. A read of 0x10 still returns the prior value.
- Out of range, DEPTH=64: read 0xFC → err=0 ack; read 0x100 → err=1 rdata=0.
- Change addr and wdata during WAIT (0x10→0x20) → write lands at the latched 0x10; 0x20 is unchanged.
- Assert reset=0 mid-WAIT of a write to 0x08 → FSM returns to IDLE, ack=0, stall=0. A read of 0x08 returns its pre-request value.
